// File: rtl/seg_scan_ctrl.sv
// Scan controller that time-multiplexes one shared BCD-to-7-segment decoder across
// NUM_DIGITS digit positions, with frame-coherent shadowing, dead-time and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 8,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic [3:0]              bcd_out,
  output logic                    dec_en,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [3:0]              cur_digit;
  logic                    lz_run;

  // Walk from the most significant digit down; a digit is blanked only while every
  // digit at or above it is zero, so zeros below a non-zero digit stay visible.
  always_comb begin
    blank_vec = '0;
    lz_run    = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run       = lz_run && (shadow[4*k +: 4] == 4'd0);
      blank_vec[k] = (BLANK_LZ != 0) && (k != 0) && lz_run;
    end
  end

  always_comb begin
    cur_digit = 4'(shadow >> (4 * idx));
  end

  // NOTE: every register here is assigned with <= so all of them see pre-edge values;
  // that is what makes the outputs lag the state by exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      shadow     <= '0;
      bcd_out    <= 4'd0;
      dec_en     <= 1'b0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        pending <= bcd_in;
      end
      frame_done <= 1'b0;

      case (state)
        ST_BLANK: begin
          dig_sel <= '0;
          dec_en  <= 1'b0;
          if (cnt == DEAD_LAST) begin
            cnt   <= '0;
            state <= ST_ON;
            // Latch a new frame only at the start of digit 0 so a frame never mixes words.
            if (idx == '0) begin
              shadow <= pending;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_ON: begin
          dig_sel <= NUM_DIGITS'(1) << idx;
          bcd_out <= cur_digit;
          dec_en  <= ~blank_vec[idx];
          if (cnt == SCAN_LAST) begin
            cnt        <= '0;
            state      <= ST_BLANK;
            idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            frame_done <= (idx == IDX_LAST);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a position-in-frame model checked every cycle,
// plus directed loads with hand-computed expectations (second instance has BLANK_LZ=0).
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int S = 4;
  localparam int D = 1;
  localparam int P = N * (D + S);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic        load = 1'b0;

  logic [3:0]  bcd_out, bcd_out_n;
  logic        dec_en, dec_en_n;
  logic [3:0]  dig_sel, dig_sel_n;
  logic        frame_done, frame_done_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYC(D), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .bcd_out(bcd_out), .dec_en(dec_en), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYC(D), .BLANK_LZ(0)) dut_nlz (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .bcd_out(bcd_out_n), .dec_en(dec_en_n), .dig_sel(dig_sel_n), .frame_done(frame_done_n)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: the expected outputs depend only on how many clock edges have elapsed since
  // reset (position inside the frame) and on the word captured at each frame start.
  int          edge_k = 0;
  logic [15:0] pend_m = 16'h0;
  logic [15:0] shad_m = 16'h0;
  int          pos, dg, ph;
  logic        nxt_on, nxt_en_lz, nxt_fd;
  logic [3:0]  nxt_sel, nxt_bcd;
  logic        exp_on = 1'b0, exp_en_lz = 1'b0, exp_en_nlz = 1'b0, exp_fd = 1'b0;
  logic [3:0]  exp_sel = 4'h0, exp_bcd = 4'h0;

  always_comb begin
    pos       = edge_k % P;
    dg        = pos / (D + S);
    ph        = pos % (D + S);
    nxt_on    = (ph >= D);
    nxt_sel   = nxt_on ? 4'(1 << dg) : 4'h0;
    nxt_bcd   = 4'(shad_m >> (4 * dg));
    nxt_en_lz = nxt_on && ((dg == 0) || ((shad_m >> (4 * dg)) != 16'h0));
    nxt_fd    = (dg == N - 1) && (ph == D + S - 1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_k     <= 0;
      pend_m     <= 16'h0;
      shad_m     <= 16'h0;
      exp_on     <= 1'b0;
      exp_sel    <= 4'h0;
      exp_bcd    <= 4'h0;
      exp_en_lz  <= 1'b0;
      exp_en_nlz <= 1'b0;
      exp_fd     <= 1'b0;
    end else begin
      exp_on     <= nxt_on;
      exp_sel    <= nxt_sel;
      if (nxt_on) exp_bcd <= nxt_bcd;
      exp_en_lz  <= nxt_en_lz;
      exp_en_nlz <= nxt_on;
      exp_fd     <= nxt_fd;
      if (pos == D - 1) shad_m <= pend_m;
      if (load) pend_m <= bcd_in;
      edge_k <= edge_k + 1;
    end
  end

  always @(negedge clk) begin
    check("dig_sel", 16'(dig_sel), 16'(exp_sel));
    check("dec_en", 16'(dec_en), 16'(exp_en_lz));
    check("frame_done", 16'(frame_done), 16'(exp_fd));
    check("dig_sel_nlz", 16'(dig_sel_n), 16'(exp_sel));
    check("dec_en_nlz", 16'(dec_en_n), 16'(exp_en_nlz));
    if (exp_on || !rst_n) begin
      check("bcd_out", 16'(bcd_out), 16'(exp_bcd));
      check("bcd_out_nlz", 16'(bcd_out_n), 16'(exp_bcd));
    end
  end

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_sel(input logic [3:0] sel);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (dig_sel == sel) hit = 1'b1;
    end
    if (!hit) timeout_fail("wait_sel");
  endtask

  task automatic wait_frames(input int n);
    for (int f = 0; f < n; f++) begin
      bit hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (frame_done) hit = 1'b1;
      end
      if (!hit) timeout_fail("wait_frame_done");
    end
  endtask

  task automatic do_load(input logic [15:0] val);
    load   = 1'b1;
    bcd_in = val;
    @(negedge clk);
    load   = 1'b0;
  endtask

  initial begin
    int period;
    bit hit;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_dig_sel", 16'(dig_sel), 16'h0);
    check("reset_dec_en", 16'(dec_en), 16'h0);
    rst_n = 1'b1;

    // 1: blank display, frame period and digit-0-only enable
    wait_frames(1);
    period = 0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      period++;
      if (frame_done) hit = 1'b1;
    end
    check("frame_period", 16'(period), 16'd20);
    wait_sel(4'b0001);
    check("t1_d0_bcd", 16'(bcd_out), 16'h0);
    check("t1_d0_en", 16'(dec_en), 16'h1);
    wait_sel(4'b0010);
    check("t1_d1_en", 16'(dec_en), 16'h0);

    // 2: mid-frame load of 1234
    repeat (7) @(negedge clk);
    do_load(16'h1234);
    wait_frames(1);
    wait_sel(4'b0100);
    check("t2_d2_bcd", 16'(bcd_out), 16'h2);
    check("t2_d2_en", 16'(dec_en), 16'h1);
    wait_sel(4'b1000);
    check("t2_d3_bcd", 16'(bcd_out), 16'h1);

    // 3: leading-zero blanking of 0050
    do_load(16'h0050);
    wait_frames(1);
    wait_sel(4'b0010);
    check("t3_d1_bcd", 16'(bcd_out), 16'h5);
    check("t3_d1_en", 16'(dec_en), 16'h1);
    wait_sel(4'b0100);
    check("t3_d2_en", 16'(dec_en), 16'h0);
    check("t3_d2_en_nlz", 16'(dec_en_n), 16'h1);

    // 4: embedded zeros stay lit; A..F pass through
    do_load(16'h1005);
    wait_frames(1);
    wait_sel(4'b0010);
    check("t4_d1_bcd", 16'(bcd_out), 16'h0);
    check("t4_d1_en", 16'(dec_en), 16'h1);
    wait_sel(4'b1000);
    check("t4_d3_bcd", 16'(bcd_out), 16'h1);
    do_load(16'h00A0);
    wait_frames(1);
    wait_sel(4'b0010);
    check("t4_hex_bcd", 16'(bcd_out), 16'hA);
    check("t4_hex_en", 16'(dec_en), 16'h1);
    wait_sel(4'b0100);
    check("t4_hex_d2_en", 16'(dec_en), 16'h0);

    // 5: load on the frame-capture edge, then two loads in one frame
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if ((edge_k % P) == D - 1) hit = 1'b1;
    end
    if (!hit) timeout_fail("wait_boundary");
    do_load(16'h4321);
    wait_sel(4'b0010);
    check("t5_same_edge_old", 16'(bcd_out), 16'hA);
    wait_frames(1);
    wait_sel(4'b0001);
    check("t5_next_frame_d0", 16'(bcd_out), 16'h1);
    wait_sel(4'b1000);
    check("t5_next_frame_d3", 16'(bcd_out), 16'h4);
    do_load(16'h7777);
    do_load(16'h0009);
    wait_frames(1);
    wait_sel(4'b0001);
    check("t5_last_load_d0", 16'(bcd_out), 16'h9);
    wait_sel(4'b0010);
    check("t5_last_load_d1_en", 16'(dec_en), 16'h0);

    // 6: asynchronous reset during digit 2
    wait_sel(4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_dig_sel", 16'(dig_sel), 16'h0);
    check("t6_async_dec_en", 16'(dec_en), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rel_gap", 16'(dig_sel), 16'h0);
    @(negedge clk);
    check("t6_rel_dig_sel", 16'(dig_sel), 16'h1);
    check("t6_rel_bcd", 16'(bcd_out), 16'h0);
    check("t6_rel_en", 16'(dec_en), 16'h1);
    wait_frames(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
